// File: rtl/register_bank.sv
// Parametrised register bank: one write port, two combinational read ports, and a clear sweeper.
// Optional write-first forwarding on the read ports is enabled by REGISTER_BANK_BYPASS_EN.
module register_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] val,
  input  logic             load,
  input  logic [AW-1:0]    waddr,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             clear,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy,
  output logic             drop
);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_accept;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return int'(addr) < DEPTH;
  endfunction

  assign wr_accept = (state_q == IDLE) && !clear && load && in_range(waddr);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drop_d  = 1'b0;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          // Clear wins over a coincident load; that load is reported as dropped.
          state_d = SWEEP;
          idx_d   = '0;
          drop_d  = load;
        end else if (load) begin
          if (in_range(waddr)) begin
            mem_d[waddr] = val;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      SWEEP: begin
        mem_d[idx_q] = '0;
        drop_d       = load;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drop_q  <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    out_a = '0;
    out_b = '0;
    if (in_range(raddr_a)) out_a = mem_q[raddr_a];
    if (in_range(raddr_b)) out_b = mem_q[raddr_b];
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_accept && (raddr_a == waddr)) out_a = val;
    if (wr_accept && (raddr_b == waddr)) out_b = val;
`endif
  end

  assign busy = (state_q == SWEEP);
  assign drop = drop_q;

`ifndef REGISTER_BANK_BYPASS_EN
  logic unused_wr_accept;
  assign unused_wr_accept = wr_accept;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: DEPTH=8 instance for function, DEPTH=6 instance for range handling.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst, load, clear;
  logic [15:0] val;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [15:0] out_a, out_b, out_a6, out_b6;
  logic        busy, drop, busy6, drop6;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .val(val), .load(load), .waddr(waddr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .clear(clear),
    .out_a(out_a), .out_b(out_b), .busy(busy), .drop(drop)
  );

  register_bank #(.WIDTH(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .val(val), .load(load), .waddr(waddr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .clear(clear),
    .out_a(out_a6), .out_b(out_b6), .busy(busy6), .drop(drop6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] byp_exp;
    rst = 1'b1; load = 1'b0; clear = 1'b0; val = '0;
    waddr = '0; raddr_a = '0; raddr_b = '0;
    tick();
    tick();
    rst = 1'b0;
    raddr_a = 3'd0; raddr_b = 3'd7;
    #1;
    chk("rst_out_a", 32'(out_a), 32'h0);
    chk("rst_out_b", 32'(out_b), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);
    chk("rst_busy6", 32'(busy6), 32'h0);

    // basic write / read / hold
    load = 1'b1; waddr = 3'd3; val = 16'h0003;
    tick();
    load = 1'b0; raddr_a = 3'd3;
    #1;
    chk("wr3_read", 32'(out_a), 32'h0003);
    chk("wr3_drop", 32'(drop), 32'h0);
    val = 16'h000F; waddr = 3'd3;
    tick();
    chk("noload_hold", 32'(out_a), 32'h0003);

    // same-cycle view of a write: forwarded only in the bypass build
`ifdef REGISTER_BANK_BYPASS_EN
    byp_exp = 16'h1234;
`else
    byp_exp = 16'h0000;
`endif
    load = 1'b1; waddr = 3'd1; val = 16'h1234; raddr_a = 3'd1; raddr_b = 3'd3;
    #1;
    chk("bypass_same_cycle", 32'(out_a), 32'(byp_exp));
    chk("bypass_other_port", 32'(out_b), 32'h0003);
    tick();
    load = 1'b0;
    #1;
    chk("wr1_after_edge", 32'(out_a), 32'h1234);

    // fill then sweep
    for (int k = 0; k < 8; k++) begin
      load = 1'b1; waddr = 3'(k); val = 16'h00A0 + 16'(k);
      tick();
    end
    load = 1'b0; raddr_a = 3'd7; raddr_b = 3'd0;
    #1;
    chk("fill_e7", 32'(out_a), 32'h00A7);
    chk("fill_e0", 32'(out_b), 32'h00A0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("sweep_start_busy", 32'(busy), 32'h1);
    chk("sweep_start_e0_old", 32'(out_b), 32'h00A0);
    for (int k = 0; k < 8; k++) begin
      raddr_a = 3'(k);
      raddr_b = (k < 7) ? 3'(k + 1) : 3'd0;
      if (k == 1) begin
        load = 1'b1; waddr = 3'd2; val = 16'h5555;
      end
      if (k == 4) clear = 1'b1;
      tick();
      load = 1'b0; clear = 1'b0;
      #1;
      chk($sformatf("sweep_e%0d_zero", k), 32'(out_a), 32'h0);
      chk($sformatf("sweep_next_after_e%0d", k), 32'(out_b),
          (k < 7) ? 32'h00A0 + 32'(k + 1) : 32'h0);
      chk($sformatf("sweep_busy_%0d", k), 32'(busy), (k < 7) ? 32'h1 : 32'h0);
      chk($sformatf("sweep_drop_%0d", k), 32'(drop), (k == 1) ? 32'h1 : 32'h0);
    end
    raddr_a = 3'd2; raddr_b = 3'd5;
    #1;
    chk("post_sweep_e2", 32'(out_a), 32'h0);
    chk("post_sweep_e5", 32'(out_b), 32'h0);

    // clear and load collide in IDLE
    load = 1'b1; waddr = 3'd5; val = 16'h1111;
    tick();
    clear = 1'b1; load = 1'b1; waddr = 3'd5; val = 16'hBEEF; raddr_a = 3'd5;
    tick();
    clear = 1'b0; load = 1'b0;
    #1;
    chk("coll_busy", 32'(busy), 32'h1);
    chk("coll_drop", 32'(drop), 32'h1);
    chk("coll_e5_not_written", 32'(out_a), 32'h1111);
    tick();
    chk("coll_drop_clears", 32'(drop), 32'h0);
    for (int k = 0; k < 7; k++) tick();
    chk("coll_done_busy", 32'(busy), 32'h0);
    chk("coll_e5_zero", 32'(out_a), 32'h0);

    // reset aborting a sweep
    load = 1'b1; waddr = 3'd6; val = 16'h6666;
    tick();
    waddr = 3'd7; val = 16'h7777;
    tick();
    load = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; raddr_a = 3'd6; raddr_b = 3'd7;
    tick();
    tick();
    chk("midsweep_e6_old", 32'(out_a), 32'h6666);
    rst = 1'b1; load = 1'b1; waddr = 3'd6; val = 16'hDEAD;
    tick();
    rst = 1'b0; load = 1'b0;
    #1;
    chk("rst_sweep_busy", 32'(busy), 32'h0);
    chk("rst_sweep_e6", 32'(out_a), 32'h0);
    chk("rst_sweep_e7", 32'(out_b), 32'h0);
    chk("rst_sweep_drop", 32'(drop), 32'h0);
    load = 1'b1; waddr = 3'd4; val = 16'h4444; raddr_a = 3'd4;
    tick();
    load = 1'b0;
    #1;
    chk("post_rst_write", 32'(out_a), 32'h4444);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // out-of-range on DEPTH=6 instance
    load = 1'b1; waddr = 3'd5; val = 16'h0505; raddr_a = 3'd5;
    tick();
    chk("d6_e5_write", 32'(out_a6), 32'h0505);
    chk("d6_e5_drop", 32'(drop6), 32'h0);
    waddr = 3'd7; val = 16'h7777; raddr_a = 3'd7; raddr_b = 3'd6;
    #1;
    chk("d6_oor_no_forward", 32'(out_a6), 32'h0);
    tick();
    load = 1'b0;
    #1;
    chk("d6_oor_drop", 32'(drop6), 32'h1);
    chk("d6_oor_read7", 32'(out_a6), 32'h0);
    chk("d6_oor_read6", 32'(out_b6), 32'h0);
    chk("d8_e7_write", 32'(out_a), 32'h7777);
    chk("d8_no_drop", 32'(drop), 32'h0);
    tick();
    chk("d6_drop_clears", 32'(drop6), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
